alarm_zone_scheduler: RTL
=========================

// Module: alarm_zone_scheduler
// PURPOSE
//  Multi-zone alarm controller: NZ intrusion zones share ONE delay timer (exit/entry
//  delay counter) inside the block. Sequences arming, round-robin arbitrates the timer
//  between triggered zones, drives a single siren. Sits between zone sensors and the
//  siren driver; replaces a per-zone timer scheme.
// PARAMETERS
//  NZ        4   number of zones (>=2)
//  TW        5   shared timer width, bits
//  EXIT_DLY  29  cycles spent in EXIT_WAIT after arming (1..2**TW)
//  ENTRY_DLY 29  grace cycles a granted zone is timed before alarm (1..2**TW)
// PORTS
//  clock      in  1   rising-edge clock
//  areset_n   in  1   asynchronous, active-low reset
//  inicio     in  1   arm request, level; 0 = disarm
//  intruso    in  NZ  per-zone intrusion sensors, level, synchronous to clock
//  zone_mask  in  NZ  1 = zone enabled; masked zones never request
//  sirena     out 1   siren drive
//  armed      out 1   1 in ARMED, ENTRY_WAIT, ALARM
//  grant      out NZ  one-hot zone owning the timer; 0 when timer is not owned
//  pending    out NZ  sticky per-zone request register
//  timer_busy out 1   shared counter running (EXIT_WAIT or ENTRY_WAIT)
// BEHAVIOUR
//  - Reset: state DISARMED; counter, pending, grant, rr_ptr = 0; all outputs 0.
//  - All outputs are decoded from registers only (Moore); no input->output comb path.
//  - inicio=0 in any state -> DISARMED next edge; pending, grant, counter cleared.
//    Overrides every other transition.
//  - DISARMED: inicio=1 -> EXIT_WAIT, counter=0.
//  - EXIT_WAIT: counter+1 per cycle. At count==EXIT_DLY-1 -> ARMED, counter=0, so
//    exactly EXIT_DLY cycles in EXIT_WAIT. intruso ignored; pending stays 0.
//  - Request vector req = (intruso & zone_mask) | pending.
//  - pending: set by intruso & zone_mask in ARMED, ENTRY_WAIT and ALARM; bits with
//    zone_mask=0 are cleared every cycle.
//  - ARMED: if req!=0 -> ENTRY_WAIT; grant = first set bit of req scanning
//    rr_ptr, rr_ptr+1, ... mod NZ; counter=0.
//  - ENTRY_WAIT: counter+1 per cycle; grant held. At count==ENTRY_DLY-1:
//      intruso[g]=1 -> ALARM (g = granted index);
//      intruso[g]=0 -> ARMED, pending[g] cleared, grant=0, rr_ptr=(g+1) mod NZ.
//    Granted zone masked mid-wait -> ARMED immediately, same clearing as above.
//  - ALARM: sirena=1, grant held, counter idle at 0. Other zones keep accumulating
//    pending. Exit depends on ALARM_LATCH_EN (CONFIGURATION).
//  - A zone re-triggering after being cleared is re-queued normally; no starvation:
//    each served zone moves rr_ptr past itself.
//  - Simultaneous triggers in one cycle: all latch into pending; served in RR order.
//  - sirena=1 only in ALARM; armed/timer_busy per PORTS.
//  - Counter compare is exact equality on TW bits; no wrap possible within range.
// CONFIGURATION
//  ALARM_LATCH_EN defined: ALARM is held until inicio=0; intruso[g] dropping has no
//    effect; sirena stays 1.
//  ALARM_LATCH_EN undefined: in ALARM, intruso[g]=0 -> ARMED next edge, pending[g]
//    cleared, grant=0, rr_ptr=(g+1) mod NZ; sirena drops one cycle later.
// TESTING (NZ=4, TW=5, EXIT_DLY=4, ENTRY_DLY=3 unless noted)
//  1 reset mid-ALARM: areset_n=0 async -> sirena=0, grant=0, pending=0, armed=0 at once.
//  2 arm: inicio 0->1 -> timer_busy=1 for 4 cycles, then armed=1; intruso=4'hF
//    during EXIT_WAIT -> pending stays 0.
//  3 false trigger: intruso=4'b0010 for 1 cycle in ARMED -> grant=4'b0010 for 3 cycles,
//    then ARMED, pending=0, sirena never 1, rr_ptr=2.
//  4 real trigger: intruso[1] held -> ENTRY_WAIT 3 cycles, ALARM, sirena=1; release
//    -> sirena=0 next cycle (latch off) / stays 1 until inicio=0 (ALARM_LATCH_EN).
//  5 RR: intruso=4'b1001 pulse, rr_ptr=0 -> grant 4'b0001 then 4'b1000; with
//    rr_ptr=1 -> 4'b1000 first.
//  6 disarm mid-ENTRY_WAIT / mask granted zone: inicio=0 -> DISARMED, all cleared;
//    zone_mask[g]=0 -> ARMED next edge, pending[g]=0, no alarm.

Source files
------------

// File: rtl/alarm_zone_scheduler.sv
// Multi-zone alarm controller: NZ zones share one exit/entry delay timer, arbitrated round-robin.
// Optional macro ALARM_LATCH_EN: when defined, ALARM holds until disarm instead of following the granted sensor.
module alarm_zone_scheduler #(
    parameter int unsigned NZ        = 4,
    parameter int unsigned TW        = 5,
    parameter int unsigned EXIT_DLY  = 29,
    parameter int unsigned ENTRY_DLY = 29
) (
    input  logic          clock,
    input  logic          areset_n,
    input  logic          inicio,
    input  logic [NZ-1:0] intruso,
    input  logic [NZ-1:0] zone_mask,
    output logic          sirena,
    output logic          armed,
    output logic [NZ-1:0] grant,
    output logic [NZ-1:0] pending,
    output logic          timer_busy
);

    localparam int unsigned PW = $clog2(NZ);
    localparam int unsigned SW = PW + 1;
    localparam logic [TW-1:0] EXIT_LAST  = TW'(EXIT_DLY - 1);
    localparam logic [TW-1:0] ENTRY_LAST = TW'(ENTRY_DLY - 1);

    typedef enum logic [2:0] {
        DISARMED,
        EXIT_WAIT,
        ARMED,
        ENTRY_WAIT,
        ALARM
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] counter, counter_next;
    logic [NZ-1:0] pending_next, grant_next, req;
    logic [PW-1:0] rr_ptr, rr_next, g_idx, pick_idx;
    logic [SW-1:0] scan;
    logic          pick_found, serve_done;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state   <= DISARMED;
            counter <= '0;
            pending <= '0;
            grant   <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
            pending <= pending_next;
            grant   <= grant_next;
            rr_ptr  <= rr_next;
        end
    end

    // Round-robin scan starting at rr_ptr, plus index of the current owner.
    always_comb begin
        req        = (intruso | pending) & zone_mask;
        pick_idx   = '0;
        pick_found = 1'b0;
        scan       = '0;
        for (int unsigned i = 0; i < NZ; i++) begin
            scan = {1'b0, rr_ptr} + SW'(i);
            if (scan >= SW'(NZ))
                scan = scan - SW'(NZ);
            if (!pick_found && req[scan[PW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[PW-1:0];
            end
        end
        g_idx = '0;
        for (int unsigned j = 0; j < NZ; j++)
            if (grant[j])
                g_idx = PW'(j);
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        pending_next = pending;
        grant_next   = grant;
        rr_next      = rr_ptr;
        serve_done   = 1'b0;
        case (state)
            DISARMED: begin
                counter_next = '0;
                if (inicio)
                    state_next = EXIT_WAIT;
            end
            EXIT_WAIT: begin
                if (counter == EXIT_LAST) begin
                    state_next   = ARMED;
                    counter_next = '0;
                end else begin
                    counter_next = counter + TW'(1);
                end
            end
            ARMED: begin
                pending_next = (pending | intruso) & zone_mask;
                if (pick_found) begin
                    state_next           = ENTRY_WAIT;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    counter_next         = '0;
                end
            end
            ENTRY_WAIT: begin
                pending_next = (pending | intruso) & zone_mask;
                if (!zone_mask[g_idx]) begin
                    serve_done = 1'b1;
                end else if (counter == ENTRY_LAST) begin
                    if (intruso[g_idx]) begin
                        state_next   = ALARM;
                        counter_next = '0;
                    end else begin
                        serve_done = 1'b1;
                    end
                end else begin
                    counter_next = counter + TW'(1);
                end
            end
            ALARM: begin
                pending_next = (pending | intruso) & zone_mask;
                counter_next = '0;
`ifdef ALARM_LATCH_EN
                serve_done   = 1'b0;
`else
                if (!intruso[g_idx])
                    serve_done = 1'b1;
`endif
            end
            default: state_next = DISARMED;
        endcase

        // Releasing the timer: owner dropped from the queue, pointer moves past it.
        if (serve_done) begin
            state_next          = ARMED;
            counter_next        = '0;
            grant_next          = '0;
            pending_next[g_idx] = 1'b0;
            rr_next             = (g_idx == PW'(NZ - 1)) ? '0 : g_idx + PW'(1);
        end

        if (!inicio) begin
            state_next   = DISARMED;
            counter_next = '0;
            pending_next = '0;
            grant_next   = '0;
        end
    end

    always_comb begin
        sirena     = (state == ALARM);
        armed      = (state == ARMED) || (state == ENTRY_WAIT) || (state == ALARM);
        timer_busy = (state == EXIT_WAIT) || (state == ENTRY_WAIT);
    end

endmodule
